bcd_timer_modn: RTL and testbench

- Parametrised cascaded BCD timer: DIGITS modulo-N digit counters chained by borrow/carry. Default configuration is mm:ss (moduli 10,6,10,6 from LSD up).
- Supports up/down mode, synchronous parallel load with per-digit clamping, enable gating, and optional halt at terminal value with a one-cycle done pulse.
- Sits between the 1 Hz tick enable and the display decoders in the timer path. Generalises the single mod-10 digit counter to any digit count and modulus set.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_digit_modn.sv | 50 +++++
 rtl/bcd_timer_modn.sv | 91 +++++++++
 tb/tb_bcd_timer_modn.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded BCD timer.
// Digit moduli are packed 4 bits per digit, LSD at bit 0.
package timer_pkg;

  localparam int DIGIT_W = 4;

  function automatic int mod_of(
    input logic [31:0] mods,
    input int          i
  );
    return int'({28'd0, mods[DIGIT_W*i +: DIGIT_W]});
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] val,
    input int                 m
  );
    logic [DIGIT_W-1:0] mx;
    mx = DIGIT_W'(m - 1);
    return (int'({28'd0, val}) >= m) ? mx : val;
  endfunction

endpackage

// File: rtl/bcd_digit_modn.sv
// One modulo-MOD BCD digit with load, step and direction.
// term flags the terminal value for the current direction.
module bcd_digit_modn
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               term
);

  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MOD - 1);

  if (MOD < 2 || MOD > 10) begin : g_bad_mod
    $error("bcd_digit_modn: MOD must be 2..10");
  end

  logic [DIGIT_W-1:0] q_d;
  logic [DIGIT_W-1:0] q_q;

  // next digit value: load wins over a count step
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = clamp_digit(d, MOD);
    end else if (step) begin
      if (up) begin
        q_d = (q_q == MAXV) ? '0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == '0) ? MAXV : q_q - 4'd1;
      end
    end
  end

  // digit register with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q    = q_q;
  assign term = up ? (q_q == MAXV) : (q_q == '0);

endmodule

// File: rtl/bcd_timer_modn.sv
// Cascaded modulo-N BCD timer: up/down, load with clamp,
// optional halt at terminal value with a one-cycle done pulse.
module bcd_timer_modn
  import timer_pkg::*;
#(
  parameter int                    DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]   MODS        = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter bit                    HALT_AT_END = 1'b1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    loadneg,
  input  logic [4*DIGITS-1:0]     data,
  input  logic                    en,
  input  logic                    up,
  output logic [4*DIGITS-1:0]     out,
  output logic                    tc,
  output logic                    zero,
  output logic                    done
);

  localparam logic [31:0] MODS32 = 32'(MODS);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_timer_modn: DIGITS must be 1..8");
  end

  logic              load;
  logic              run;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] nterm;
  logic              done_d;
  logic              done_q;

  assign load = ~loadneg;
  assign tc   = &term;
  assign zero = (out == '0);
  assign run  = en & ~(HALT_AT_END & tc);

  // ripple step: a digit moves when all lower digits are terminal
  always_comb begin
    logic lower;
    step  = '0;
    lower = run;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = lower;
      lower   = lower & term[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam int MI = mod_of(MODS32, i);
    localparam logic [DIGIT_W-1:0] MX = DIGIT_W'(MI - 1);

    logic [DIGIT_W-1:0] qi;

    bcd_digit_modn #(
      .MOD (MI)
    ) u_digit (
      .clk   (clk),
      .clear (clear),
      .load  (load),
      .d     (data[DIGIT_W*i +: DIGIT_W]),
      .step  (step[i]),
      .up    (up),
      .q     (qi),
      .term  (term[i])
    );

    assign out[DIGIT_W*i +: DIGIT_W] = qi;

    assign nterm[i] = up
      ? (step[i] ? (qi == MX - 4'd1) : (qi == MX))
      : (step[i] ? (qi == 4'd1)      : (qi == 4'd0));
  end

  // done fires when a count step lands on the terminal value
  always_comb begin
    done_d = run & loadneg & (&nterm);
  end

  // done register with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;

endmodule

// File: tb/tb_bcd_timer_modn.sv
// Bench for bcd_timer_modn: halting and wrapping instances
// checked against a mixed-radix integer model every cycle.
module tb_bcd_timer_modn;

  localparam logic [15:0] MODS = {4'd6, 4'd10, 4'd6, 4'd10};
  localparam int NTOT = 3600;

  logic        clk = 1'b0;
  logic        clear, loadneg, en, up;
  logic [15:0] data;
  logic [15:0] out_h, out_w;
  logic        tc_h, tc_w, zero_h, zero_w, done_h, done_w;

  int n_chk  = 0;
  int n_fail = 0;

  int mh, mw;
  bit mdh, mdw;
  bit mv = 1'b0;

  always #5 clk = ~clk;

  bcd_timer_modn #(
    .DIGITS (4), .MODS (MODS), .HALT_AT_END (1'b1)
  ) dut_h (
    .clk (clk), .clear (clear), .loadneg (loadneg),
    .data (data), .en (en), .up (up),
    .out (out_h), .tc (tc_h), .zero (zero_h), .done (done_h)
  );

  bcd_timer_modn #(
    .DIGITS (4), .MODS (MODS), .HALT_AT_END (1'b0)
  ) dut_w (
    .clk (clk), .clear (clear), .loadneg (loadneg),
    .data (data), .en (en), .up (up),
    .out (out_w), .tc (tc_w), .zero (zero_w), .done (done_w)
  );

  function automatic int md(input int i);
    logic [15:0] m;
    m = MODS;
    return int'({28'd0, m[4*i +: 4]});
  endfunction

  function automatic int to_idx(input logic [15:0] d);
    int idx, w, v;
    idx = 0;
    w   = 1;
    for (int i = 0; i < 4; i++) begin
      v = int'({28'd0, d[4*i +: 4]});
      if (v > md(i) - 1) v = md(i) - 1;
      idx += v * w;
      w   *= md(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] to_bcd(input int idx);
    logic [15:0] r;
    int x;
    r = '0;
    x = idx;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % md(i));
      x = x / md(i);
    end
    return r;
  endfunction

  function automatic bit is_term(input int idx, input bit u);
    return u ? (idx == NTOT - 1) : (idx == 0);
  endfunction

  function automatic int nxt(input int cur, input bit u, input bit halt);
    if (halt && is_term(cur, u)) return cur;
    return u ? (cur + 1) % NTOT : (cur + NTOT - 1) % NTOT;
  endfunction

  function automatic bit dn(input int cur, input bit u, input bit halt);
    if (halt && is_term(cur, u)) return 1'b0;
    return is_term(nxt(cur, u, halt), u);
  endfunction

  always @(posedge clk) begin
    if (clear) begin
      mh <= 0; mw <= 0; mdh <= 1'b0; mdw <= 1'b0; mv <= 1'b1;
    end else if (!loadneg) begin
      mh <= to_idx(data); mw <= to_idx(data);
      mdh <= 1'b0; mdw <= 1'b0;
    end else if (en) begin
      mh  <= nxt(mh, up, 1'b1); mw  <= nxt(mw, up, 1'b0);
      mdh <= dn(mh, up, 1'b1);  mdw <= dn(mw, up, 1'b0);
    end else begin
      mdh <= 1'b0; mdw <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mv) begin
      chk("m_out_h",  32'(out_h),  32'(to_bcd(mh)));
      chk("m_done_h", 32'(done_h), 32'(mdh));
      chk("m_tc_h",   32'(tc_h),   32'(is_term(mh, up)));
      chk("m_zero_h", 32'(zero_h), 32'(mh == 0));
      chk("m_out_w",  32'(out_w),  32'(to_bcd(mw)));
      chk("m_done_w", 32'(done_w), 32'(mdw));
      chk("m_tc_w",   32'(tc_w),   32'(is_term(mw, up)));
      chk("m_zero_w", 32'(zero_w), 32'(mw == 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [15:0] v);
    loadneg = 1'b0; data = v;
    cyc();
    loadneg = 1'b1;
  endtask

  initial begin
    clear = 1'b1; loadneg = 1'b0; en = 1'b1; up = 1'b0;
    data = 16'h1234;
    cyc();
    clear = 1'b0; loadneg = 1'b1; en = 1'b0;
    chk("rst_out",  32'(out_h), 32'h0000);
    chk("rst_zero", 32'(zero_h), 32'd1);
    chk("rst_tc",   32'(tc_h), 32'd1);
    chk("rst_done", 32'(done_h), 32'd0);

    load(16'h0105);
    chk("ld_0105", 32'(out_h), 32'h0105);
    en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      cyc();
      if (i == 1) chk("dn_0104", 32'(out_h), 32'h0104);
      if (i == 5) chk("dn_0100", 32'(out_h), 32'h0100);
      if (i == 6) chk("dn_0059", 32'(out_h), 32'h0059);
      if (i == 7) chk("dn_0058", 32'(out_h), 32'h0058);
      if (i == 64) chk("dn_done0", 32'(done_h), 32'd0);
    end
    chk("dn_end", 32'(out_h), 32'h0000);
    chk("dn_done", 32'(done_h), 32'd1);
    cyc();
    chk("dn_hold", 32'(out_h), 32'h0000);
    chk("dn_hold_done", 32'(done_h), 32'd0);
    chk("dn_wrap_w", 32'(out_w), 32'h5959);

    en = 1'b0;
    load(16'h0A7C);
    chk("clamp", 32'(out_h), 32'h0959);

    up = 1'b1;
    load(16'h5958);
    en = 1'b1;
    cyc();
    chk("up_5959", 32'(out_w), 32'h5959);
    chk("up_tc", 32'(tc_w), 32'd1);
    chk("up_done", 32'(done_w), 32'd1);
    cyc();
    chk("up_wrap", 32'(out_w), 32'h0000);
    chk("up_wrap_done", 32'(done_w), 32'd0);
    chk("up_wrap_zero", 32'(zero_w), 32'd1);
    chk("up_halt", 32'(out_h), 32'h5959);
    chk("up_halt_done", 32'(done_h), 32'd0);

    en = 1'b0;
    repeat (3) cyc();
    chk("en_hold", 32'(out_w), 32'h0000);
    load(16'h0007);
    chk("ld_no_en", 32'(out_h), 32'h0007);

    up = 1'b0;
    load(16'h0030);
    en = 1'b1;
    cyc();
    chk("ms_0029", 32'(out_h), 32'h0029);
    up = 1'b1;
    cyc();
    chk("ms_0030", 32'(out_h), 32'h0030);
    up = 1'b0;
    repeat (4) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_mid", 32'(out_h), 32'h0000);
    chk("clr_done", 32'(done_h), 32'd0);
    en = 1'b0;
    #1 chk("tc_dn", 32'(tc_h), 32'd1);
    up = 1'b1;
    #1 chk("tc_up", 32'(tc_h), 32'd0);
    up = 1'b0;
    #1 chk("tc_back", 32'(tc_h), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      clear   = ($urandom % 64) == 0;
      loadneg = ($urandom % 16) != 0;
      en      = ($urandom % 4) != 0;
      if (($urandom % 32) == 0) up = ~up;
      case ($urandom % 4)
        0:       data = 16'h0001;
        1:       data = 16'h5958;
        default: data = 16'($urandom);
      endcase
    end
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
